// File: rtl/wavetable_pkg.sv
// Shared types and sizing for the wavetable bank.
// Optional feature macro used by wavetable_bank: WT_SWAP_CNT_EN.
package wavetable_pkg;
    localparam int WT_ADDR_W = 8;
    localparam int WT_DEPTH  = 1 << WT_ADDR_W;
    localparam int WT_DATA_W = 16;

    typedef enum logic [1:0] {
        WT_IDLE  = 2'd0,
        WT_FILL  = 2'd1,
        WT_ARMED = 2'd2
    } wt_state_t;
endpackage

// File: rtl/wt_dpram.sv
// Simple dual-port RAM holding both banks; address is {bank_bit, index}.
// Contents are never reset; only the registered read output is.
module wt_dpram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              we,
    input  logic [ADDR_W:0]   waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W:0]   raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [0:(2 << ADDR_W)-1];

    // Loader write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port: one clk from address to data.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/wavetable_bank.sv
// Double-buffered wavetable: NCO reads the active bank while a loader fills
// the other; the swap happens only at a phase wrap (or a forced sync).
// Optional macro WT_SWAP_CNT_EN adds swap_cnt and the sticky ovr flag.
//
// Loader handshake: a beat transfers on a rising clk where wr_valid and
// wr_ready are both 1; while wr_valid=1 and wr_ready=0 the loader holds
// wr_data/wr_last stable. wr_ready is 0 in ARMED and during reset.
module wavetable_bank
    import wavetable_pkg::*;
#(
    parameter int DATA_W = WT_DATA_W,
    parameter int ADDR_W = WT_ADDR_W,
    parameter int DEPTH  = WT_DEPTH
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [ADDR_W-1:0] adr,
    input  logic              clk2,
    input  logic              sync,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output logic [DATA_W-1:0] sample,
    output logic              bank,
    output logic              armed,
    output wt_state_t         dbg_state
`ifdef WT_SWAP_CNT_EN
    ,
    output logic [7:0]        swap_cnt,
    output logic              ovr
`endif
);
    wt_state_t         state, next_state;
    logic [ADDR_W-1:0] idx;
    logic              clk2_q;
    logic              wrap;
    logic              hs;
    logic              do_write;
    logic              do_swap;

    assign wrap      = clk2_q & ~clk2;
    assign hs        = wr_valid & wr_ready;
    assign armed     = (state == WT_ARMED);
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= WT_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: accept beats until last/full, then wait for a swap event.
    always_comb begin
        next_state = state;
        do_write   = 1'b0;
        do_swap    = 1'b0;
        case (state)
            WT_IDLE: begin
                if (hs) begin
                    do_write   = 1'b1;
                    next_state = (wr_last || DEPTH == 1) ? WT_ARMED : WT_FILL;
                end
            end
            WT_FILL: begin
                if (hs) begin
                    do_write   = 1'b1;
                    if (wr_last || idx == ADDR_W'(DEPTH - 1)) begin
                        next_state = WT_ARMED;
                    end
                end
            end
            WT_ARMED: begin
                if (wrap || sync) begin
                    do_swap    = 1'b1;
                    next_state = WT_IDLE;
                end
            end
            default: next_state = WT_IDLE;
        endcase
    end

    // Wrap history, loader ready, fill index and active bank.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            clk2_q   <= 1'b0;
            wr_ready <= 1'b0;
            idx      <= '0;
            bank     <= 1'b0;
        end else begin
            clk2_q   <= clk2;
            wr_ready <= (next_state != WT_ARMED);
            if (do_swap) begin
                bank <= ~bank;
                idx  <= '0;
            end else if (do_write && next_state == WT_FILL) begin
                idx <= idx + 1'b1;
            end
        end
    end

`ifdef WT_SWAP_CNT_EN
    // Swap counter and sticky flag for a wrap+sync collision (one request lost).
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            swap_cnt <= 8'd0;
            ovr      <= 1'b0;
        end else begin
            if (do_swap) begin
                swap_cnt <= swap_cnt + 8'd1;
            end
            if (state == WT_ARMED && wrap && sync) begin
                ovr <= 1'b1;
            end
        end
    end
`endif

    wt_dpram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .clr_n (clr_n),
        .we    (do_write),
        .waddr ({~bank, idx}),
        .wdata (wr_data),
        .raddr ({bank, adr}),
        .rdata (sample)
    );
endmodule

// File: tb/tb_wavetable_bank.sv
// Directed bench for wavetable_bank with a per-cycle behavioural model.
module tb_wavetable_bank;
    import wavetable_pkg::*;

    logic        clk = 1'b0;
    logic        clr_n = 1'b1;
    logic [7:0]  adr = 8'd0;
    logic        clk2 = 1'b0;
    logic        sync = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] wr_data = 16'd0;
    logic        wr_last = 1'b0;
    logic [15:0] sample;
    logic        bank;
    logic        armed;
    wt_state_t   dbg_state;
`ifdef WT_SWAP_CNT_EN
    logic [7:0]  swap_cnt;
    logic        ovr;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    wavetable_bank dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .adr       (adr),
        .clk2      (clk2),
        .sync      (sync),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .wr_last   (wr_last),
        .sample    (sample),
        .bank      (bank),
        .armed     (armed),
        .dbg_state (dbg_state)
`ifdef WT_SWAP_CNT_EN
        ,
        .swap_cnt  (swap_cnt),
        .ovr       (ovr)
`endif
    );

    // Clock / reset.
    always #5 clk = ~clk;

    // Behavioural model: two banks of samples, a beat count for the current
    // load, and a loaded-and-waiting flag.
    logic [15:0] m_mem [0:1][0:255];
    bit          m_valid [0:1][0:255];
    bit          m_bank = 0, m_armed = 0, m_ready = 0, m_clk2_q = 0, m_ovr = 0;
    int          m_cnt = 0;
    logic [7:0]  m_swaps = 8'd0;
    logic [15:0] e_sample = 16'd0;
    bit          e_valid = 1;

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_bank = 0; m_armed = 0; m_ready = 0; m_clk2_q = 0;
            m_cnt = 0; m_swaps = 8'd0; m_ovr = 0;
            e_sample = 16'd0; e_valid = 1;
        end else begin
            bit hs, wr;
            hs = wr_valid && m_ready;
            wr = m_clk2_q && !clk2;
            e_valid  = m_valid[m_bank][adr];
            e_sample = m_mem[m_bank][adr];
            if (m_armed) begin
                if (wr || sync) begin
                    if (wr && sync) m_ovr = 1;
                    m_bank  = ~m_bank;
                    m_armed = 0;
                    m_cnt   = 0;
                    m_swaps = m_swaps + 8'd1;
                end
            end else if (hs) begin
                m_mem[~m_bank][m_cnt]   = wr_data;
                m_valid[~m_bank][m_cnt] = 1;
                m_cnt = m_cnt + 1;
                if (wr_last || m_cnt == 256) m_armed = 1;
            end
            m_ready  = !m_armed;
            m_clk2_q = clk2;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            wt_state_t e_state;
            e_state = m_armed ? WT_ARMED : (m_cnt == 0 ? WT_IDLE : WT_FILL);
            if (e_valid) chk("sample", 32'(sample), 32'(e_sample));
            chk("bank", 32'(bank), 32'(m_bank));
            chk("armed", 32'(armed), 32'(m_armed));
            chk("wr_ready", 32'(wr_ready), 32'(m_ready));
            chk("state", 32'(dbg_state), 32'(e_state));
`ifdef WT_SWAP_CNT_EN
            chk("swap_cnt", 32'(swap_cnt), 32'(m_swaps));
            chk("ovr", 32'(ovr), 32'(m_ovr));
`endif
        end
    end

    // Driver tasks.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input bit last);
        int n;
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = last;
        n = 0;
        while (!wr_ready && n < 50) begin
            tick();
            n++;
        end
        if (!wr_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: wr_ready stuck at 0, expected 1");
        end
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic wrap_pulse();
        clk2 = 1'b1;
        tick(); tick();
        clk2 = 1'b0;
        tick(); tick();
    endtask

    initial begin
        #2 clr_n = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("rst_sample", 32'(sample), 32'h0);
        chk("rst_wr_ready", 32'(wr_ready), 32'h0);
        chk("rst_bank", 32'(bank), 32'h0);
        repeat (2) tick();
        clr_n = 1'b1;
        tick(); tick();
        chk("idle_ready", 32'(wr_ready), 32'h1);

        // Full ramp load into bank 1, then 8 wraps: exactly one swap.
        for (int i = 0; i < 256; i++) send(16'(i), i == 255);
        chk("t1_armed", 32'(armed), 32'h1);
        chk("t1_ready", 32'(wr_ready), 32'h0);
        repeat (8) wrap_pulse();
        chk("t1_bank", 32'(bank), 32'h1);
        adr = 8'h40;
        tick();
        chk("t1_sample", 32'(sample), 32'h0040);

        // Full load into bank 0 without wr_last; forced swap via sync.
        for (int i = 0; i < 256; i++) send(16'h1000 + 16'(i), 1'b0);
        chk("t3_armed", 32'(armed), 32'h1);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        chk("t3_bank", 32'(bank), 32'h0);
        chk("t3_armed0", 32'(armed), 32'h0);
        chk("t3_ready", 32'(wr_ready), 32'h1);
        adr = 8'h05;
        tick();
        chk("t3_sample", 32'(sample), 32'h1005);

        // Short load of 10 beats into bank 1 (still holding the ramp).
        for (int i = 0; i < 10; i++) send(16'h7FFF, i == 9);
        chk("t2_armed", 32'(armed), 32'h1);
        chk("t2_ready", 32'(wr_ready), 32'h0);
        wrap_pulse();
        chk("t2_bank", 32'(bank), 32'h1);
        adr = 8'd9;
        tick();
        chk("t2_adr9", 32'(sample), 32'h7FFF);
        adr = 8'd10;
        tick();
        chk("t2_adr10", 32'(sample), 32'h000A);

        // Final write coincides with a wrap: no swap until the next wrap.
        for (int i = 0; i < 4; i++) send(16'h2222, 1'b0);
        clk2 = 1'b1;
        tick();
        clk2 = 1'b0;
        send(16'h2222, 1'b1);
        chk("t4_armed", 32'(armed), 32'h1);
        tick(); tick();
        chk("t4_bank_hold", 32'(bank), 32'h1);
        wrap_pulse();
        chk("t4_bank", 32'(bank), 32'h0);
        adr = 8'd3;
        tick();
        chk("t4_adr3", 32'(sample), 32'h2222);
        adr = 8'd5;
        tick();
        chk("t4_adr5", 32'(sample), 32'h1005);

        // Reset in the middle of a fill at index 100.
        for (int i = 0; i < 100; i++) send(16'h5000 + 16'(i), 1'b0);
        chk("t5_fill", 32'(dbg_state), 32'(WT_FILL));
        clr_n = 1'b0;
        #1;
        chk("t5_bank", 32'(bank), 32'h0);
        chk("t5_sample", 32'(sample), 32'h0);
        chk("t5_ready", 32'(wr_ready), 32'h0);
        tick();
        clr_n = 1'b1;
        tick(); tick();
        chk("t5_idle", 32'(dbg_state), 32'(WT_IDLE));
        chk("t5_ready1", 32'(wr_ready), 32'h1);

`ifdef WT_SWAP_CNT_EN
        // Three loads and swaps, then a wrap+sync collision.
        for (int k = 0; k < 3; k++) begin
            send(16'h0001, 1'b0);
            send(16'h0002, 1'b1);
            wrap_pulse();
        end
        chk("t6_cnt3", 32'(swap_cnt), 32'h3);
        chk("t6_ovr0", 32'(ovr), 32'h0);
        send(16'h0003, 1'b1);
        clk2 = 1'b1;
        tick();
        clk2 = 1'b0;
        sync = 1'b1;
        tick();
        sync = 1'b0;
        chk("t6_ovr1", 32'(ovr), 32'h1);
        chk("t6_cnt4", 32'(swap_cnt), 32'h4);
        repeat (20) tick();
        chk("t6_ovr_sticky", 32'(ovr), 32'h1);
`endif

        tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
